// File: rtl/fixed_rrelu_backward_if.sv
// Stream bundle for the RReLU backward block: forward-input stream, upstream
// gradient stream and the registered downstream gradient stream with last marker.
interface fixed_rrelu_backward_if #(
    parameter int W = 8,
    parameter int P = 1
);
    logic [P-1:0][W-1:0] fwd_in_0;
    logic                fwd_in_0_valid;
    logic                fwd_in_0_ready;

    logic [P-1:0][W-1:0] grad_in_0;
    logic                grad_in_0_valid;
    logic                grad_in_0_ready;

    logic [P-1:0][W-1:0] grad_out_0;
    logic                grad_out_0_valid;
    logic                grad_out_0_ready;
    logic                grad_out_0_last;

    modport slave (
        input  fwd_in_0, fwd_in_0_valid,
        output fwd_in_0_ready,
        input  grad_in_0, grad_in_0_valid,
        output grad_in_0_ready,
        output grad_out_0, grad_out_0_valid, grad_out_0_last,
        input  grad_out_0_ready
    );

    modport master (
        output fwd_in_0, fwd_in_0_valid,
        input  fwd_in_0_ready,
        output grad_in_0, grad_in_0_valid,
        input  grad_in_0_ready,
        input  grad_out_0, grad_out_0_valid, grad_out_0_last,
        output grad_out_0_ready
    );
endinterface

// File: rtl/fixed_rrelu_backward.sv
// Fixed-point RReLU backward pass: forward-input signs are queued as masks and
// joined with gradient beats. Define FIXED_RRELU_BACKWARD_SAT_EN to saturate the slope path.
module fixed_rrelu_backward #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter logic [DATA_IN_0_PRECISION_0-1:0] NEGATIVE_SLOPE = 8'd2,
    parameter int MASK_FIFO_DEPTH             = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fixed_rrelu_backward_if.slave  bus
);

    localparam int W     = DATA_IN_0_PRECISION_0;
    localparam int F     = DATA_IN_0_PRECISION_1;
    localparam int P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int BEATS = (DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1) / P;
    localparam int AW    = $clog2(MASK_FIFO_DEPTH);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [CW-1:0] BEAT_ONE  = CW'(1);
    localparam logic [CW-1:0] BEAT_LAST = CW'(BEATS - 1);

    // Mask FIFO state
    logic [P-1:0] mask_mem [MASK_FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         mask_full;
    logic         mask_empty;
    logic [P-1:0] mask_in;
    logic [P-1:0] mask_rd;

    // Output stage state
    logic [P-1:0][W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       beat_q, beat_d;

    logic                push;
    logic                pop;
    logic                out_fire;
    logic                grad_ready;
    logic [P-1:0][W-1:0] result;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign mask_empty = (wr_ptr_q == rd_ptr_q);
    assign mask_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign grad_ready = !mask_empty && (!valid_q || bus.grad_out_0_ready);
    assign push       = bus.fwd_in_0_valid && !mask_full;
    assign pop        = bus.grad_in_0_valid && grad_ready;
    assign out_fire   = valid_q && bus.grad_out_0_ready;

    assign bus.fwd_in_0_ready   = !mask_full;
    assign bus.grad_in_0_ready  = grad_ready;
    assign bus.grad_out_0       = data_q;
    assign bus.grad_out_0_valid = valid_q;
    assign bus.grad_out_0_last  = valid_q && (beat_q == BEAT_LAST);

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_mask
            // Zero takes the slope, matching the forward activation's condition.
            assign mask_in[gi] = bus.fwd_in_0[gi][W-1] || (bus.fwd_in_0[gi] == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_q[AW-1:0]] <= mask_in;
        end
    end

    // Asynchronous read so the popped mask pairs with the gradient accepted this cycle.
    assign mask_rd = mask_mem[rd_ptr_q[AW-1:0]];

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_elem
            logic signed [2*W-1:0] prod;
            logic        [W-1:0]   slope_val;

            assign prod = $signed(bus.grad_in_0[gi]) * $signed(NEGATIVE_SLOPE);

`ifdef FIXED_RRELU_BACKWARD_SAT_EN
            localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
            localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
            logic signed [2*W-1:0] shifted;

            assign shifted = prod >>> F;

            always_comb begin
                if (shifted > SAT_MAX) begin
                    slope_val = SAT_MAX[W-1:0];
                end else if (shifted < SAT_MIN) begin
                    slope_val = SAT_MIN[W-1:0];
                end else begin
                    slope_val = shifted[W-1:0];
                end
            end
`else
            assign slope_val = W'(prod >>> F);
`endif

            assign result[gi] = mask_rd[gi] ? slope_val : bus.grad_in_0[gi];
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        beat_d   = beat_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // A new beat can only load when the register is empty or draining.
        if (pop) begin
            data_d  = result;
            valid_d = 1'b1;
        end else if (bus.grad_out_0_ready) begin
            valid_d = 1'b0;
        end

        if (out_fire) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            beat_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            beat_q   <= beat_d;
        end
    end

endmodule
